// File: rtl/seg_scan_display.sv
// Multiplexed N-digit 7-segment scanner: frame-synchronous shadow inputs, leading-zero blanking, blink, dp, 16-level PWM.
// One register stage from counter state to pins; free-running, no backpressure.
module seg_scan_display #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 3125,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit EN_ACT_LOW   = 1'b1
) (
    input  logic                  sysclk,
    input  logic                  rstn,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic [DIGITS-1:0]     blinkMask,
    input  logic                  lzSuppress,
    input  logic [3:0]            bright,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     segEn,
    output logic                  frameStart
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]     PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]     DIG_LAST   = DW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]        SEG_OFF    = {7{SEG_ACT_LOW}};
    localparam logic              DP_OFF     = SEG_ACT_LOW;
    localparam logic [DIGITS-1:0] EN_OFF     = {DIGITS{EN_ACT_LOW}};

    logic [PW-1:0] pre;
    logic [3:0]    sub;
    logic [DW-1:0] dig;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    logic [4*DIGITS-1:0] sh_digits;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blink;
    logic                sh_lz;
    logic [3:0]          sh_bright;
    logic                sh_blank;

    logic frame_load;
    logic pre_wrap;
    logic sub_wrap;
    logic frame_end;

    assign frame_load = (pre == '0) && (sub == 4'd0) && (dig == '0);
    assign pre_wrap   = (pre == PRE_LAST);
    assign sub_wrap   = pre_wrap && (sub == 4'd15);
    assign frame_end  = sub_wrap && (dig == DIG_LAST);

    // On the load cycle the live inputs feed the display path, so the first
    // digit-0 output cycle of a frame already belongs to the new frame.
    logic [4*DIGITS-1:0] cur_digits;
    logic [DIGITS-1:0]   cur_dp;
    logic [DIGITS-1:0]   cur_blink;
    logic                cur_lz;
    logic [3:0]          cur_bright;
    logic                cur_blank;

    assign cur_digits = frame_load ? digits     : sh_digits;
    assign cur_dp     = frame_load ? dpIn       : sh_dp;
    assign cur_blink  = frame_load ? blinkMask  : sh_blink;
    assign cur_lz     = frame_load ? lzSuppress : sh_lz;
    assign cur_bright = frame_load ? bright     : sh_bright;
    assign cur_blank  = frame_load ? blank      : sh_blank;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // A digit is suppressed while it and every digit above it are zero.
    logic [DIGITS-1:0] supp;
    always_comb begin
        logic run;
        supp = '0;
        run  = cur_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run     = run && (cur_digits[4*i +: 4] == 4'd0);
            supp[i] = run;
        end
    end

    logic [3:0]        cur_val;
    logic              active;
    logic [6:0]        seg_raw;
    logic              dp_raw;
    logic [DIGITS-1:0] en_raw;

    assign cur_val = cur_digits[{dig, 2'b00} +: 4];
    assign active  = !cur_blank && (sub <= cur_bright) && !(cur_blink[dig] && blink_ph);

    always_comb begin
        en_raw      = '0;
        en_raw[dig] = active;
        seg_raw     = (active && !supp[dig]) ? glyph(cur_val) : 7'h00;
        dp_raw      = active && cur_dp[dig];
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            pre        <= '0;
            sub        <= 4'd0;
            dig        <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            sh_lz      <= 1'b0;
            sh_bright  <= 4'd0;
            sh_blank   <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            segEn      <= EN_OFF;
            frameStart <= 1'b0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                sub <= sub + 4'd1;
            end
            if (sub_wrap) begin
                dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (frame_load) begin
                sh_digits <= digits;
                sh_dp     <= dpIn;
                sh_blink  <= blinkMask;
                sh_lz     <= lzSuppress;
                sh_bright <= bright;
                sh_blank  <= blank;
            end
            seg        <= seg_raw ^ SEG_OFF;
            dp         <= dp_raw ^ DP_OFF;
            segEn      <= en_raw ^ EN_OFF;
            frameStart <= frame_load;
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a time-based reference model pushes the expected
// pin state for every clock, a monitor pops and compares both polarity variants.
module tb_seg_scan_display;
    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int SLOT         = 16 * SCAN_DIV;
    localparam int FRAME        = DIGITS * SLOT;

    logic                clk  = 1'b0;
    logic                rstn = 1'b0;
    logic [4*DIGITS-1:0] digits     = '0;
    logic [DIGITS-1:0]   dp_in      = '0;
    logic [DIGITS-1:0]   blink_mask = '0;
    logic                lz         = 1'b0;
    logic [3:0]          bright     = 4'd0;
    logic                blank      = 1'b0;

    logic [6:0]        seg, seg_lo;
    logic              dp, dp_lo;
    logic [DIGITS-1:0] seg_en, en_lo;
    logic              frame_start, fs_lo;

    seg_scan_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES),
        .SEG_ACT_LOW(1'b0), .EN_ACT_LOW(1'b0)
    ) dut (
        .sysclk(clk), .rstn(rstn), .digits(digits), .dpIn(dp_in), .blinkMask(blink_mask),
        .lzSuppress(lz), .bright(bright), .blank(blank),
        .seg(seg), .dp(dp), .segEn(seg_en), .frameStart(frame_start)
    );

    seg_scan_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES),
        .SEG_ACT_LOW(1'b1), .EN_ACT_LOW(1'b1)
    ) dut_lo (
        .sysclk(clk), .rstn(rstn), .digits(digits), .dpIn(dp_in), .blinkMask(blink_mask),
        .lzSuppress(lz), .bright(bright), .blank(blank),
        .seg(seg_lo), .dp(dp_lo), .segEn(en_lo), .frameStart(fs_lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]        seg;
        logic              dp;
        logic [DIGITS-1:0] en;
        logic              fs;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t        = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [4*DIGITS-1:0] f_digits;
    logic [DIGITS-1:0]   f_dp, f_blink;
    logic                f_lz, f_blank;
    logic [3:0]          f_bright;

    // Expected pins for the cycle that follows clock edge number tt after reset release.
    function automatic obs_t model(int tt);
        obs_t e;
        int   d, s, hi;
        bit   ph, active, supp;
        d  = (tt / SLOT) % DIGITS;
        s  = (tt / SCAN_DIV) % 16;
        ph = (((tt / FRAME) / BLINK_FRAMES) % 2) == 1;
        hi = 0;
        for (int i = 0; i < DIGITS; i++)
            if (f_digits[4*i +: 4] != 4'd0) hi = i;
        supp   = f_lz && (d > hi);
        active = !f_blank && (s <= int'(f_bright)) && !(f_blink[d] && ph);
        e    = '0;
        e.fs = (tt % FRAME) == 0;
        if (active) begin
            e.en[d] = 1'b1;
            e.dp    = f_dp[d];
            if (!supp) e.seg = glyph_tab[f_digits[4*d +: 4]];
        end
        return e;
    endfunction

    always @(posedge clk) begin
        obs_t e;
        if (!rstn) begin
            t = 0;
            e = '0;
        end else begin
            if (t % FRAME == 0) begin
                f_digits = digits;
                f_dp     = dp_in;
                f_blink  = blink_mask;
                f_lz     = lz;
                f_bright = bright;
                f_blank  = blank;
            end
            e = model(t);
            t++;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        obs_t e, e_lo, a, a_lo;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rstn) e = '0;  // reset forces inactive pins immediately
            e_lo = {~e.seg, ~e.dp, ~e.en, e.fs};
            a    = {seg, dp, seg_en, frame_start};
            a_lo = {seg_lo, dp_lo, en_lo, fs_lo};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL pins_act_high @%0t: got seg=%h dp=%b en=%b fs=%b, expected seg=%h dp=%b en=%b fs=%b",
                         $time, a.seg, a.dp, a.en, a.fs, e.seg, e.dp, e.en, e.fs);
            end
            n_checks++;
            if (a_lo !== e_lo) begin
                n_fail++;
                $display("FAIL pins_act_low @%0t: got seg=%h dp=%b en=%b fs=%b, expected seg=%h dp=%b en=%b fs=%b",
                         $time, a_lo.seg, a_lo.dp, a_lo.en, a_lo.fs, e_lo.seg, e_lo.dp, e_lo.en, e_lo.fs);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        digits = 16'h1234;
        bright = 4'd15;
        step(3);
        rstn = 1'b1;
        step(40);
        digits = 16'h5678;
        step(2 * FRAME - 40);

        lz     = 1'b1;
        digits = 16'h0040;
        dp_in  = 4'b1100;
        step(FRAME + 17);
        digits = 16'h0000;
        step(FRAME);
        lz     = 1'b0;
        dp_in  = 4'b0101;
        digits = 16'hABCD;

        bright = 4'd3;
        step(2 * FRAME);
        bright = 4'd15;
        blink_mask = 4'b0001;
        digits = 16'hEF90;
        step(5 * FRAME);
        blank = 1'b1;
        step(FRAME);
        blank = 1'b0;

        for (int k = 0; k < 40; k++) begin
            digits     = (4*DIGITS)'($urandom);
            dp_in      = DIGITS'($urandom);
            blink_mask = DIGITS'($urandom);
            lz         = 1'($urandom);
            bright     = 4'($urandom);
            blank      = ($urandom_range(0, 7) == 0);
            step($urandom_range(1, 200));
        end

        // Asynchronous reset in the middle of a slot, away from any edge.
        digits = 16'h8421;
        bright = 4'd15;
        blank  = 1'b0;
        blink_mask = '0;
        step(FRAME + 45);
        @(posedge clk);
        #2 rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(FRAME + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
